// File: rtl/fetch_stage_pkg.sv
// Shared pipeline constants for the fetch stage: reset defaults, PC increment
// and word-alignment mask. FETCH_PERF_CNT_EN (in fetch_stage) adds perf counters.
package fetch_stage_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] PC_INCR           = 32'd4;
  localparam logic [31:0] WORD_ALIGN_MASK   = 32'hFFFF_FFFC;

  function automatic logic [31:0] alignPc(input logic [31:0] addr);
    return addr & WORD_ALIGN_MASK;
  endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register set; a squash loads a bubble and beats a stall.
module if_id_reg
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        squash_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] pcplus4_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic [31:0] pcplus4_o,
  output logic        valid_o
);

  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pcplus4_q, pcplus4_d;
  logic        valid_q, valid_d;

  always_comb begin
    instr_d   = instr_q;
    pc_d      = pc_q;
    pcplus4_d = pcplus4_q;
    valid_d   = valid_q;
    if (squash_i) begin
      instr_d   = NOP_INSTR;
      pc_d      = '0;
      pcplus4_d = '0;
      valid_d   = 1'b0;
    end else if (!stall_i) begin
      instr_d   = instr_i;
      pc_d      = pc_i;
      pcplus4_d = pcplus4_i;
      valid_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_q   <= NOP_INSTR;
      pc_q      <= '0;
      pcplus4_q <= '0;
      valid_q   <= 1'b0;
    end else begin
      instr_q   <= instr_d;
      pc_q      <= pc_d;
      pcplus4_q <= pcplus4_d;
      valid_q   <= valid_d;
    end
  end

  assign instr_o   = instr_q;
  assign pc_o      = pc_q;
  assign pcplus4_o = pcplus4_q;
  assign valid_o   = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: PC register, redirect/stall priority and IF/ID register.
// Define FETCH_PERF_CNT_EN to add fetch_cnt/bubble_cnt performance counters.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallF,
  input  logic        redirectE,
  input  logic [31:0] redirect_pcE,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instrD,
  output logic [31:0] pcD,
  output logic [31:0] pcplus4D,
  output logic        validD,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0] fetch_cnt,
  output logic [31:0] bubble_cnt,
`endif
  output logic        flushD
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] pcPlus4;
  logic        advance;

  assign imem_addr = alignPc(pc_q);
  assign pcPlus4   = imem_addr + PC_INCR;
  assign advance   = !redirectE && !stallF;
  assign flushD    = redirectE;

  always_comb begin
    pc_d = pc_q;
    if (redirectE) begin
      pc_d = alignPc(redirect_pcE);
    end else if (!stallF) begin
      pc_d = pcPlus4;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= alignPc(RESET_PC);
    end else begin
      pc_q <= pc_d;
    end
  end

  if_id_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id (
    .clk       (clk),
    .rst       (rst),
    .stall_i   (stallF),
    .squash_i  (redirectE),
    .instr_i   (imem_rdata),
    .pc_i      (imem_addr),
    .pcplus4_i (pcPlus4),
    .instr_o   (instrD),
    .pc_o      (pcD),
    .pcplus4_o (pcplus4D),
    .valid_o   (validD)
  );

`ifdef FETCH_PERF_CNT_EN
  // Every non-reset edge is either a useful fetch or a bubble (stall/redirect).
  logic [31:0] fetchCnt_q, bubbleCnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetchCnt_q  <= '0;
      bubbleCnt_q <= '0;
    end else if (advance) begin
      fetchCnt_q  <= fetchCnt_q + 32'd1;
    end else begin
      bubbleCnt_q <= bubbleCnt_q + 32'd1;
    end
  end

  assign fetch_cnt  = fetchCnt_q;
  assign bubble_cnt = bubbleCnt_q;
`else
  logic unusedAdvance;
  assign unusedAdvance = advance;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage with a combinational imem model.
// Counter checks are compiled in when FETCH_PERF_CNT_EN is defined.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        stallF;
  logic        redirectE;
  logic [31:0] redirect_pcE;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] instrD;
  logic [31:0] pcD;
  logic [31:0] pcplus4D;
  logic        validD;
  logic        flushD;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt;
  logic [31:0] bubble_cnt;
`endif

  int checks;
  int errors;

  always #5 clk = ~clk;

  // Instruction memory model: PC 0 holds the reference word, others are address-tagged.
  function automatic logic [31:0] instrAt(input logic [31:0] addr);
    return (addr == 32'h0) ? 32'h2001_0005 : {16'hBEEF, addr[15:0]};
  endfunction

  assign imem_rdata = instrAt(imem_addr);

  fetch_stage #(
    .RESET_PC  (32'h0000_0000),
    .NOP_INSTR (NOP)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .stallF       (stallF),
    .redirectE    (redirectE),
    .redirect_pcE (redirect_pcE),
    .imem_addr    (imem_addr),
    .imem_rdata   (imem_rdata),
    .instrD       (instrD),
    .pcD          (pcD),
    .pcplus4D     (pcplus4D),
    .validD       (validD),
`ifdef FETCH_PERF_CNT_EN
    .fetch_cnt    (fetch_cnt),
    .bubble_cnt   (bubble_cnt),
`endif
    .flushD       (flushD)
  );

  task automatic applyStimulus(input logic r, input logic s, input logic red,
                               input logic [31:0] target);
    rst          = r;
    stallF       = s;
    redirectE    = red;
    redirect_pcE = target;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic stepEdge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;

    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("resetPc", imem_addr, 32'h0);
    checkOutput("resetValid", {31'b0, validD}, 32'h0);
    checkOutput("resetInstr", instrD, NOP);
    checkOutput("resetPcD", pcD, 32'h0);
    checkOutput("resetPcPlus4D", pcplus4D, 32'h0);
    checkOutput("resetFlushIdle", {31'b0, flushD}, 32'h0);
    redirectE = 1'b1;
    #1;
    checkOutput("resetFlushFollows", {31'b0, flushD}, 32'h1);
    redirectE = 1'b0;

    rst = 1'b0;
    stepEdge();
    checkOutput("firstInstr", instrD, 32'h2001_0005);
    checkOutput("firstPcD", pcD, 32'h0);
    checkOutput("firstPcPlus4D", pcplus4D, 32'h4);
    checkOutput("firstValid", {31'b0, validD}, 32'h1);
    checkOutput("firstPcNext", imem_addr, 32'h4);

    stepEdge();
    checkOutput("advPc", imem_addr, 32'h8);
    checkOutput("advPcD", pcD, 32'h4);

    stallF = 1'b1;
    for (int i = 0; i < 3; i++) begin
      stepEdge();
      checkOutput("stallPc", imem_addr, 32'h8);
      checkOutput("stallPcD", pcD, 32'h4);
      checkOutput("stallInstr", instrD, instrAt(32'h4));
      checkOutput("stallValid", {31'b0, validD}, 32'h1);
    end
    stallF = 1'b0;
    stepEdge();
    checkOutput("resumePcD", pcD, 32'h8);
    checkOutput("resumeInstr", instrD, instrAt(32'h8));
    checkOutput("resumePc", imem_addr, 32'hC);

    applyStimulus(1'b0, 1'b1, 1'b1, 32'h0000_0040);
    #1;
    checkOutput("redirFlush", {31'b0, flushD}, 32'h1);
    stepEdge();
    checkOutput("redirPc", imem_addr, 32'h40);
    checkOutput("redirValid", {31'b0, validD}, 32'h0);
    checkOutput("redirInstr", instrD, NOP);
    checkOutput("redirPcD", pcD, 32'h0);
    checkOutput("redirPcPlus4D", pcplus4D, 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    #1;
    checkOutput("flushDrop", {31'b0, flushD}, 32'h0);
    stepEdge();
    checkOutput("postRedirPcD", pcD, 32'h40);
    checkOutput("postRedirValid", {31'b0, validD}, 32'h1);
    checkOutput("postRedirInstr", instrD, instrAt(32'h40));
    checkOutput("postRedirPc", imem_addr, 32'h44);

    applyStimulus(1'b0, 1'b0, 1'b1, 32'h0000_0043);
    stepEdge();
    checkOutput("alignPc", imem_addr, 32'h40);

    applyStimulus(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
    stepEdge();
    checkOutput("topPc", imem_addr, 32'hFFFF_FFFC);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    stepEdge();
    checkOutput("wrapPc", imem_addr, 32'h0);
    checkOutput("wrapPcPlus4D", pcplus4D, 32'h0);
    checkOutput("wrapPcD", pcD, 32'hFFFF_FFFC);
    checkOutput("wrapInstr", instrD, instrAt(32'hFFFF_FFFC));

    applyStimulus(1'b0, 1'b0, 1'b1, 32'h0000_001C);
    stepEdge();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    stepEdge();
    checkOutput("midPc", imem_addr, 32'h20);
    checkOutput("midValid", {31'b0, validD}, 32'h1);

    rst = 1'b1;
    #1;
    checkOutput("asyncRstPc", imem_addr, 32'h0);
    checkOutput("asyncRstValid", {31'b0, validD}, 32'h0);
    checkOutput("asyncRstInstr", instrD, NOP);
    checkOutput("asyncRstPcD", pcD, 32'h0);
`ifdef FETCH_PERF_CNT_EN
    checkOutput("asyncRstFetchCnt", fetch_cnt, 32'h0);
    checkOutput("asyncRstBubbleCnt", bubble_cnt, 32'h0);
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;

    stepEdge();
    checkOutput("postRstPcD", pcD, 32'h0);
    checkOutput("postRstInstr", instrD, 32'h2001_0005);
    checkOutput("postRstPc", imem_addr, 32'h4);
    repeat (4) stepEdge();
    stallF = 1'b1;
    repeat (2) stepEdge();
    stallF = 1'b0;
    checkOutput("perfPc", imem_addr, 32'h14);
    checkOutput("perfPcD", pcD, 32'h10);
`ifdef FETCH_PERF_CNT_EN
    checkOutput("fetchCnt", fetch_cnt, 32'd5);
    checkOutput("bubbleCnt", bubble_cnt, 32'd2);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
